// File: rtl/suma_pkg.sv
// Shared definitions for the ASCII two-digit adder sequencer.
// Optional build macro: SUMA_CRLF_EN adds CR/LF terminator states to the
// output frame. Without it, a frame ends after the units character.
package suma_pkg;

    // Controller states. The terminator states only exist when the
    // CR/LF frame terminator is built in.
`ifdef SUMA_CRLF_EN
    typedef enum logic [3:0] {
        RX_AT = 4'd0,
        RX_AU = 4'd1,
        RX_BT = 4'd2,
        RX_BU = 4'd3,
        CALC  = 4'd4,
        TX_C  = 4'd5,
        TX_D  = 4'd6,
        TX_U  = 4'd7,
        TX_CR = 4'd8,
        TX_LF = 4'd9
    } state_t;
`else
    typedef enum logic [3:0] {
        RX_AT = 4'd0,
        RX_AU = 4'd1,
        RX_BT = 4'd2,
        RX_BU = 4'd3,
        CALC  = 4'd4,
        TX_C  = 4'd5,
        TX_D  = 4'd6,
        TX_U  = 4'd7
    } state_t;
`endif

    // ASCII codes used by the receive and transmit paths.
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Threshold for the hundreds split.
    localparam logic [7:0] CIEN = 8'd100;

    // True for the four digit-collection states.
    function automatic logic is_rx_state(input state_t s);
        logic r;
        case (s)
            RX_AT, RX_AU, RX_BT, RX_BU: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    // True for every state that presents a character downstream.
    function automatic logic is_tx_state(input state_t s);
        logic r;
        case (s)
            TX_C, TX_D, TX_U: r = 1'b1;
`ifdef SUMA_CRLF_EN
            TX_CR, TX_LF:     r = 1'b1;
`endif
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    // True for an ASCII decimal digit '0'..'9'.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // Converts a BCD digit into its ASCII character.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return ASCII_0 + {4'd0, d};
    endfunction

endpackage

// File: rtl/dividir_centenas.sv
// Combinational split of a binary sum (0..198) into a hundreds flag and the
// tens/units digits of the remainder below one hundred.
module dividir_centenas
    import suma_pkg::*;
(
    input  logic [7:0] sum,
    output logic       cc,
    output logic [3:0] rd,
    output logic [3:0] ru
);

    logic [7:0] rem_s;

    // Strip the hundreds, then divide the remainder by ten.
    always_comb begin
        cc = (sum >= CIEN);
        if (cc) begin
            rem_s = sum - CIEN;
        end else begin
            rem_s = sum;
        end
        // The remainder is below 100, so both results fit in four bits.
        rd = 4'(rem_s / 8'd10);
        ru = 4'(rem_s % 8'd10);
    end

endmodule

// File: rtl/suma_ascii_ctrl.sv
// Sequencer for the ASCII two-digit adder: collects four ASCII digits
// (A tens, A units, B tens, B units) over a valid/ready byte stream, adds
// A+B and streams the result back as ASCII characters.
// Optional build macro: SUMA_CRLF_EN appends CR and LF to every result frame.
module suma_ascii_ctrl
    import suma_pkg::*;
#(
    parameter logic [7:0] CLR_CHAR  = 8'h1B,
    parameter int         LEAD_ZERO = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       err,
    output logic [7:0] sum_bin,
    output logic       cc
);

    localparam logic LZ_EN = (LEAD_ZERO != 32'sd0);

    // FSM state
    state_t     state_r;
    state_t     state_nxt_s;

    // Collected operand digits
    logic [3:0] at_r;
    logic [3:0] au_r;
    logic [3:0] bt_r;
    logic [3:0] bu_r;

    // Result registers loaded in CALC
    logic [7:0] sum_bin_r;
    logic       cc_r;
    logic [3:0] rd_r;
    logic [3:0] ru_r;

    // Registered handshake/status outputs
    logic       in_ready_r;
    logic       out_valid_r;
    logic [7:0] out_data_r;
    logic       busy_r;
    logic       err_r;

    // Next values for the registered outputs
    logic       in_ready_nxt_s;
    logic       out_valid_nxt_s;
    logic [7:0] out_data_nxt_s;
    logic       busy_nxt_s;
    logic       err_nxt_s;

    // Byte classification and handshakes
    logic       accept_s;
    logic       digit_acc_s;
    logic       clr_acc_s;
    logic       rej_acc_s;
    logic [3:0] digit_s;
    logic       tx_fire_s;

    // Arithmetic
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic [7:0] sum_s;
    logic       split_cc_s;
    logic [3:0] split_rd_s;
    logic [3:0] split_ru_s;
    logic       cc_v_s;
    logic [3:0] rd_v_s;
    logic [3:0] ru_v_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign sum_bin   = sum_bin_r;
    assign cc        = cc_r;

    // in_ready is only ever high in a receive state, so an accepted byte
    // always belongs to digit collection.
    assign accept_s    = in_valid && in_ready_r;
    assign digit_acc_s = accept_s && is_digit(in_data);
    assign clr_acc_s   = accept_s && (in_data == CLR_CHAR);
    assign rej_acc_s   = accept_s && !is_digit(in_data) && (in_data != CLR_CHAR);
    assign digit_s     = 4'(in_data - ASCII_0);
    assign tx_fire_s   = out_valid_r && out_ready;

    // Two-digit operands; the largest sum (99+99) still fits in 8 bits.
    assign a_s   = ({4'd0, at_r} * 8'd10) + {4'd0, au_r};
    assign b_s   = ({4'd0, bt_r} * 8'd10) + {4'd0, bu_r};
    assign sum_s = a_s + b_s;

    dividir_centenas u_split (
        .sum (sum_s),
        .cc  (split_cc_s),
        .rd  (split_rd_s),
        .ru  (split_ru_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RX_AT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: digit entry, one calc cycle, then the output frame.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RX_AT: begin
                if (digit_acc_s) begin
                    state_nxt_s = RX_AU;
                end else begin
                    state_nxt_s = RX_AT;
                end
            end
            RX_AU: begin
                if (digit_acc_s) begin
                    state_nxt_s = RX_BT;
                end else if (clr_acc_s) begin
                    state_nxt_s = RX_AT;
                end else begin
                    state_nxt_s = RX_AU;
                end
            end
            RX_BT: begin
                if (digit_acc_s) begin
                    state_nxt_s = RX_BU;
                end else if (clr_acc_s) begin
                    state_nxt_s = RX_AT;
                end else begin
                    state_nxt_s = RX_BT;
                end
            end
            RX_BU: begin
                if (digit_acc_s) begin
                    state_nxt_s = CALC;
                end else if (clr_acc_s) begin
                    state_nxt_s = RX_AT;
                end else begin
                    state_nxt_s = RX_BU;
                end
            end
            CALC: begin
                // The hundreds character is skipped only for short results
                // when leading zeros are disabled.
                if (LZ_EN || split_cc_s) begin
                    state_nxt_s = TX_C;
                end else begin
                    state_nxt_s = TX_D;
                end
            end
            TX_C: begin
                if (tx_fire_s) begin
                    state_nxt_s = TX_D;
                end else begin
                    state_nxt_s = TX_C;
                end
            end
            TX_D: begin
                if (tx_fire_s) begin
                    state_nxt_s = TX_U;
                end else begin
                    state_nxt_s = TX_D;
                end
            end
            TX_U: begin
                if (tx_fire_s) begin
`ifdef SUMA_CRLF_EN
                    state_nxt_s = TX_CR;
`else
                    state_nxt_s = RX_AT;
`endif
                end else begin
                    state_nxt_s = TX_U;
                end
            end
`ifdef SUMA_CRLF_EN
            TX_CR: begin
                if (tx_fire_s) begin
                    state_nxt_s = TX_LF;
                end else begin
                    state_nxt_s = TX_CR;
                end
            end
            TX_LF: begin
                if (tx_fire_s) begin
                    state_nxt_s = RX_AT;
                end else begin
                    state_nxt_s = TX_LF;
                end
            end
`endif
            default: begin
                state_nxt_s = RX_AT;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a register.
    always_comb begin
        // In CALC the result registers load on the same edge as the first
        // character, so the split outputs are used directly.
        if (state_r == CALC) begin
            cc_v_s = split_cc_s;
            rd_v_s = split_rd_s;
            ru_v_s = split_ru_s;
        end else begin
            cc_v_s = cc_r;
            rd_v_s = rd_r;
            ru_v_s = ru_r;
        end

        in_ready_nxt_s  = is_rx_state(state_nxt_s);
        out_valid_nxt_s = is_tx_state(state_nxt_s);
        busy_nxt_s      = !is_rx_state(state_nxt_s);
        err_nxt_s       = rej_acc_s;

        case (state_nxt_s)
            TX_C:    out_data_nxt_s = ASCII_0 + {7'd0, cc_v_s};
            TX_D:    out_data_nxt_s = to_ascii(rd_v_s);
            TX_U:    out_data_nxt_s = to_ascii(ru_v_s);
`ifdef SUMA_CRLF_EN
            TX_CR:   out_data_nxt_s = ASCII_CR;
            TX_LF:   out_data_nxt_s = ASCII_LF;
`endif
            default: out_data_nxt_s = 8'h00;
        endcase
    end

    // Registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            busy_r      <= busy_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    // Digit capture: clear char wipes all digits, a digit lands in the slot
    // selected by the current receive state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_r <= 4'd0;
            au_r <= 4'd0;
            bt_r <= 4'd0;
            bu_r <= 4'd0;
        end else if (clr_acc_s) begin
            at_r <= 4'd0;
            au_r <= 4'd0;
            bt_r <= 4'd0;
            bu_r <= 4'd0;
        end else if (digit_acc_s) begin
            case (state_r)
                RX_AT:   at_r <= digit_s;
                RX_AU:   au_r <= digit_s;
                RX_BT:   bt_r <= digit_s;
                RX_BU:   bu_r <= digit_s;
                default: at_r <= at_r;
            endcase
        end else begin
            at_r <= at_r;
        end
    end

    // Result capture in CALC; held until the next calculation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_bin_r <= 8'd0;
            cc_r      <= 1'b0;
            rd_r      <= 4'd0;
            ru_r      <= 4'd0;
        end else if (state_r == CALC) begin
            sum_bin_r <= sum_s;
            cc_r      <= split_cc_s;
            rd_r      <= split_rd_s;
            ru_r      <= split_ru_s;
        end else begin
            sum_bin_r <= sum_bin_r;
        end
    end

endmodule

// File: tb/tb_suma_ascii_ctrl.sv
// Self-checking bench for suma_ascii_ctrl. Two instances share the input
// stream and out_ready: one with leading zeros, one without. A reference
// model predicts each frame from the accepted keystrokes.
module tb_suma_ascii_ctrl;

`ifdef SUMA_CRLF_EN
    localparam int CRN = 2;
`else
    localparam int CRN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready1, out_valid1, busy1, err1, cc1;
    logic [7:0] out_data1, sum_bin1;
    logic       in_ready0, out_valid0, busy0, err0, cc0;
    logic [7:0] out_data0, sum_bin0;

    always #5 clk = ~clk;

    suma_ascii_ctrl #(.CLR_CHAR(8'h1B), .LEAD_ZERO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .busy(busy1), .err(err1), .sum_bin(sum_bin1), .cc(cc1)
    );

    suma_ascii_ctrl #(.CLR_CHAR(8'h1B), .LEAD_ZERO(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ready(out_ready), .busy(busy0), .err(err0), .sum_bin(sum_bin0), .cc(cc0)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int or_mode = 0;   // 0: ready high, 1: ready low, 2: random, 3: driven by main
    int nfr = 0;
    int last_acc = 0;
    logic exp_accept = 1'b0;
    logic exp_err_r = 1'b0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];
    int         sumq[$];
    int         digs[$];
    logic [7:0] fb[5];
    int         fn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected character frame for a sum, straight from decimal arithmetic.
    function automatic void frame(input int s, input bit lz, output logic [7:0] b[5], output int n);
        int h;
        int r;
        h = s / 100;
        r = s % 100;
        n = 0;
        for (int i = 0; i < 5; i++) b[i] = 8'h00;
        if (lz || h != 0) begin b[n] = 8'(48 + h); n++; end
        b[n] = 8'(48 + r / 10); n++;
        b[n] = 8'(48 + r % 10); n++;
`ifdef SUMA_CRLF_EN
        b[n] = 8'h0D; n++;
        b[n] = 8'h0A; n++;
`endif
    endfunction

    // Model reaction to an accepted keystroke.
    task automatic model_accept(input logic [7:0] b);
        logic [7:0] lb[5];
        int n;
        int s;
        if (b >= 8'h30 && b <= 8'h39) begin
            digs.push_back(int'(b) - 48);
            if (digs.size() == 4) begin
                s = 10 * digs[0] + digs[1] + 10 * digs[2] + digs[3];
                sumq.push_back(s);
                frame(s, 1'b1, lb, n);
                for (int i = 0; i < n; i++) q1.push_back(lb[i]);
                frame(s, 1'b0, lb, n);
                for (int i = 0; i < n; i++) q0.push_back(lb[i]);
                last_acc = cyc;
                nfr++;
                digs.delete();
            end
        end else if (b == 8'h1B) begin
            digs.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready1 && in_ready0) break;
        end
        if (k == 300) chk("send_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
        in_valid = 1'b1;
        in_data = b;
        exp_accept = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_accept = 1'b0;
        model_accept(b);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            #3;
            if (q1.size() == 0 && q0.size() == 0 && !out_valid1 && !out_valid0) break;
        end
        chk("drain_q1", q1.size(), 0);
        chk("drain_q0", q0.size(), 0);
        chk("idle_busy1", busy1, 1'b0);
        chk("idle_busy0", busy0, 1'b0);
        chk("idle_in_ready1", in_ready1, 1'b1);
    endtask

    task automatic wait_valid1();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (out_valid1) break;
        end
        chk("wait_out_valid1", out_valid1, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready1"}, in_ready1, 1'b0);
        chk({tag, "_out_valid1"}, out_valid1, 1'b0);
        chk({tag, "_out_data1"}, out_data1, 8'h00);
        chk({tag, "_busy1"}, busy1, 1'b0);
        chk({tag, "_err1"}, err1, 1'b0);
        chk({tag, "_sum_bin1"}, sum_bin1, 8'h00);
        chk({tag, "_cc1"}, cc1, 1'b0);
        chk({tag, "_out_valid0"}, out_valid0, 1'b0);
        chk({tag, "_busy0"}, busy0, 1'b0);
    endtask

    function automatic logic [7:0] junk();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255));
        while ((v >= 8'h30 && v <= 8'h39) || v == 8'h1B);
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // An err pulse is expected exactly one cycle after an accepted reject.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_err_r <= 1'b0;
        else exp_err_r <= in_valid && exp_accept && !(in_data >= 8'h30 && in_data <= 8'h39)
                          && (in_data != 8'h1B);
    end

    // out_ready driver, changes well away from both clock edges.
    initial forever begin
        @(posedge clk);
        #2;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Per-cycle compare against the model.
    logic       pv1 = 1'b0, pr1 = 1'b0, pv0 = 1'b0, pr0 = 1'b0;
    logic [7:0] pd1 = 8'h00, pd0 = 8'h00;
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            pv1 = 1'b0;
            pv0 = 1'b0;
        end else begin
            chk("err1", err1, exp_err_r);
            chk("err0", err0, exp_err_r);
            if (pv1 && !pr1) begin
                chk("hold_valid1", out_valid1, 1'b1);
                chk("hold_data1", out_data1, pd1);
            end
            if (pv0 && !pr0) begin
                chk("hold_valid0", out_valid0, 1'b1);
                chk("hold_data0", out_data0, pd0);
            end
            if (out_valid1 && !pv1) begin
                if (sumq.size() > 0) begin
                    chk("sum_bin1", sum_bin1, sumq[0]);
                    chk("cc1", cc1, sumq[0] >= 100);
                    chk("sum_bin0", sum_bin0, sumq[0]);
                    chk("cc0", cc0, sumq[0] >= 100);
                    chk("latency", cyc, last_acc + 1);
                    void'(sumq.pop_front());
                end else begin
                    chk("unexpected_frame1", out_valid1, 1'b0);
                end
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() > 0) chk("byte1", out_data1, q1.pop_front());
                else chk("extra_byte1", out_valid1, 1'b0);
            end
            if (out_valid0 && out_ready) begin
                if (q0.size() > 0) chk("byte0", out_data0, q0.pop_front());
                else chk("extra_byte0", out_valid0, 1'b0);
            end
            pv1 = out_valid1; pr1 = out_ready; pd1 = out_data1;
            pv0 = out_valid0; pr0 = out_ready; pd0 = out_data0;
        end
    end

    initial begin
        // Hand-computed frames pin the model.
        frame(132, 1'b1, fb, fn);
        chk("pin_132", {fb[0], fb[1], fb[2]}, 24'h313332);
        chk("pin_132_len", fn, 3 + CRN);
        frame(46, 1'b0, fb, fn);
        chk("pin_46_nolz", {fb[0], fb[1]}, 16'h3436);
        chk("pin_46_nolz_len", fn, 2 + CRN);
        frame(198, 1'b1, fb, fn);
        chk("pin_198", {fb[0], fb[1], fb[2]}, 24'h313938);
        frame(100, 1'b1, fb, fn);
        chk("pin_100", {fb[0], fb[1], fb[2]}, 24'h313030);
        frame(3, 1'b1, fb, fn);
        chk("pin_3", {fb[0], fb[1], fb[2]}, 24'h303033);

        // Reset state, then in_ready rises one cycle after release.
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_rst1", in_ready1, 1'b1);
        chk("ready_after_rst0", in_ready0, 1'b1);

        // Directed frames.
        or_mode = 0;
        send4("4", "7", "8", "5"); drain();
        send4("1", "2", "3", "4"); drain();
        send4("9", "9", "9", "9"); drain();
        send4("5", "0", "5", "0"); drain();
        send("4"); send("x"); send("7"); send(8'h1B);
        send4("0", "1", "0", "2"); drain();

        // Stall at TX_D with junk on the input.
        or_mode = 3;
        out_ready = 1'b0;
        send4("1", "2", "3", "4");
        wait_valid1();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = junk();
            @(negedge clk);
            #1;
            chk("stall_valid1", out_valid1, 1'b1);
            chk("stall_data1", out_data1, 8'h34);
            chk("stall_data0", out_data0, 8'h36);
            chk("stall_in_ready1", in_ready1, 1'b0);
            chk("stall_in_ready0", in_ready0, 1'b0);
            chk("stall_busy1", busy1, 1'b1);
        end
        in_valid = 1'b0;
        or_mode = 0;
        drain();

        // Reset in the middle of a frame.
        or_mode = 3;
        out_ready = 1'b0;
        send4("4", "7", "8", "5");
        wait_valid1();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midtx_rst");
        q1.delete(); q0.delete(); sumq.delete(); digs.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        or_mode = 0;
        send4("2", "2", "2", "2"); drain();

        // Randomized keystrokes with junk, clears and random backpressure.
        or_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int start;
            int guard;
            start = nfr;
            guard = 0;
            while (nfr == start && guard < 60) begin
                int r;
                r = $urandom_range(0, 19);
                if (r == 0) send(junk());
                else if (r == 1) send(8'h1B);
                else send(8'(48 + $urandom_range(0, 9)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                guard++;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
